// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing constants. The defaults give 640x480@60 timing. The
// derived totals and sync positions are shared with the pixel generator so
// both sides agree on where the visible area and sync pulses sit.
// Contents: default H_/V_ parameters, CNT_W, sum4() helper, derived H_TOTAL,
// V_TOTAL, HS_START/HS_END and VS_START/VS_END.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int CNT_W     = 10;

   // Total period of a line or frame from its four segments.
   function automatic int sum4(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

   localparam int H_TOTAL  = sum4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL  = sum4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_sync_timing_mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
// Modulo-MOD counter that advances when en is high and wraps MOD-1 -> 0.
// Ports:
//   clock   in   rising-edge clock
//   clear_n in   asynchronous active-low reset (count -> 0)
//   en      in   advance enable
//   count   out  [WIDTH-1:0] current count
//   wrap    out  high while count sits at MOD-1 (the next enabled edge wraps)
// ----------------------------------------------------------------------------
module mod_counter #(
   parameter int MOD   = 800,
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   // Terminal-count flag, not qualified by en; callers combine it with their
   // own enable so it can also drive the cascade into the next counter.
   assign wrap = (count == LAST);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/vga_sync_timing.sv
// ----------------------------------------------------------------------------
// vga_sync_timing
// Horizontal/vertical pixel counters for the VGA controller. Emits one-clock
// set/reset pulses for the downstream hsync/vsync SR flip-flops, plus pixel
// coordinates, a visible-area flag and line/frame strobes.
// Optional feature: define VGA_FRAME_COUNT_EN to add an 8-bit frame counter
// output (frame_count) that steps each time both counters wrap together.
// Ports:
//   clock       in   rising-edge clock
//   clear_n     in   asynchronous active-low reset
//   pixel_en    in   one-clock pixel advance strobe
//   hs_reset    out  hsync ffsr reset pulse (sync start)
//   hs_set      out  hsync ffsr set pulse (sync end / init)
//   vs_reset    out  vsync ffsr reset pulse
//   vs_set      out  vsync ffsr set pulse
//   h_count     out  [CNT_W-1:0] current pixel column
//   v_count     out  [CNT_W-1:0] current line
//   visible     out  inside the active area
//   line_start  out  pixel_en pulse at column 0
//   frame_start out  pixel_en pulse at column 0, line 0
//   frame_count out  [7:0] completed frames mod 256 (VGA_FRAME_COUNT_EN only)
// ----------------------------------------------------------------------------
module vga_sync_timing
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BACK    = vga_timing_pkg::V_BACK,
   parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             pixel_en,
   output logic             hs_reset,
   output logic             hs_set,
   output logic             vs_reset,
   output logic             vs_set,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic             visible,
   output logic             line_start,
`ifdef VGA_FRAME_COUNT_EN
   output logic [7:0]       frame_count,
`endif
   output logic             frame_start
);

   localparam int H_TOTAL  = sum4(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL  = sum4(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(HS_START);
   localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(HS_END);
   localparam logic [CNT_W-1:0] VS_RST_C   = CNT_W'(VS_START - 1);
   localparam logic [CNT_W-1:0] VS_SET_C   = CNT_W'(VS_END - 1);
   localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);

   logic h_wrap;
   logic v_wrap;
   logic init_pending;
   logic active;

   mod_counter #(.MOD(H_TOTAL), .WIDTH(CNT_W)) u_hcnt (
      .clock   (clock),
      .clear_n (clear_n),
      .en      (pixel_en),
      .count   (h_count),
      .wrap    (h_wrap)
   );

   mod_counter #(.MOD(V_TOTAL), .WIDTH(CNT_W)) u_vcnt (
      .clock   (clock),
      .clear_n (clear_n),
      .en      (pixel_en & h_wrap),
      .count   (v_count),
      .wrap    (v_wrap)
   );

   // Held from reset until the first pixel advance so both sync flip-flops
   // get forced inactive whatever state they powered up in.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         init_pending <= 1'b1;
      end else if (pixel_en) begin
         init_pending <= 1'b0;
      end
   end

   // clear_n is folded in so no pulse leaks out while reset is held, even
   // with pixel_en high and init_pending set.
   assign active = pixel_en & clear_n;

   assign hs_reset    = active & (h_count == HS_START_C);
   assign hs_set      = active & ((h_count == HS_END_C) | init_pending);
   // Vertical pulses fire on the last pixel of the preceding line so the
   // ffsr changes on the same edge v_count enters/leaves the sync band.
   assign vs_reset    = active & h_wrap & (v_count == VS_RST_C);
   assign vs_set      = active & ((h_wrap & (v_count == VS_SET_C)) | init_pending);
   assign visible     = (h_count < H_VIS_C) & (v_count < V_VIS_C);
   assign line_start  = active & (h_count == '0);
   assign frame_start = active & (h_count == '0) & (v_count == '0);

`ifdef VGA_FRAME_COUNT_EN
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         frame_count <= 8'd0;
      end else if (pixel_en & h_wrap & v_wrap) begin
         frame_count <= frame_count + 8'd1;
      end
   end
`else
   // The vertical terminal count only feeds the frame counter.
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_sync_timing.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_timing
// Drives two instances: the default 640x480 timing (line-level behaviour) and
// a tiny 15x9 timing so whole frames fit in a short run. Expected outputs
// come from the number of pixel advances since reset (h = n mod H_TOTAL,
// line = n div H_TOTAL); a model SR flip-flop on each sync pair checks the
// resulting sync levels against the required low windows.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_timing;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pe = 1'b0;
   longint n = 0;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   // default instance
   logic d_hs_reset, d_hs_set, d_vs_reset, d_vs_set, d_visible, d_line_start, d_frame_start;
   logic [9:0] d_h_count, d_v_count;
   // small instance
   logic s_hs_reset, s_hs_set, s_vs_reset, s_vs_set, s_visible, s_line_start, s_frame_start;
   logic [3:0] s_h_count, s_v_count;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] d_frame_count, s_frame_count;
`endif

   vga_sync_timing dut_d (
      .clock(clk), .clear_n(rst_n), .pixel_en(pe),
      .hs_reset(d_hs_reset), .hs_set(d_hs_set), .vs_reset(d_vs_reset), .vs_set(d_vs_set),
      .h_count(d_h_count), .v_count(d_v_count), .visible(d_visible),
      .line_start(d_line_start),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count(d_frame_count),
`endif
      .frame_start(d_frame_start)
   );

   vga_sync_timing #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CNT_W(4)
   ) dut_s (
      .clock(clk), .clear_n(rst_n), .pixel_en(pe),
      .hs_reset(s_hs_reset), .hs_set(s_hs_set), .vs_reset(s_vs_reset), .vs_set(s_vs_set),
      .h_count(s_h_count), .v_count(s_v_count), .visible(s_visible),
      .line_start(s_line_start),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count(s_frame_count),
`endif
      .frame_start(s_frame_start)
   );

   // Pixel advances since the last reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n <= 0;
      else if (pe) n <= n + 1;
   end

   // Attached sync flip-flops (set wins; never both by design).
   logic d_hq = 1'b0, d_vq = 1'b0, s_hq = 1'b0, s_vq = 1'b0;
   always @(posedge clk) begin
      if (d_hs_set) d_hq <= 1'b1; else if (d_hs_reset) d_hq <= 1'b0;
      if (d_vs_set) d_vq <= 1'b1; else if (d_vs_reset) d_vq <= 1'b0;
      if (s_hs_set) s_hq <= 1'b1; else if (s_hs_reset) s_hq <= 1'b0;
      if (s_vs_set) s_vq <= 1'b1; else if (s_vs_reset) s_vq <= 1'b0;
   end

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs_r, hs_s, vs_r, vs_s, vis, ls, fs, hlvl, vlvl;
      logic [7:0]  fc;
   } exp_t;

   function automatic exp_t model(input longint cnt, input logic en, input logic rn,
                                  input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb);
      exp_t   e;
      int     ht, vt, hss, hse, vss, vse, h, v;
      longint line;
      logic   act;
      ht   = hv + hf + hsw + hb;
      vt   = vv + vf + vsw + vb;
      hss  = hv + hf;  hse = hss + hsw;
      vss  = vv + vf;  vse = vss + vsw;
      line = cnt / ht;
      h    = int'(cnt % ht);
      v    = int'(line % vt);
      act  = en && rn;
      e.h    = 16'(h);
      e.v    = 16'(v);
      e.fc   = 8'((cnt / (ht * vt)) % 256);
      e.hs_r = act && (h == hss);
      e.hs_s = act && ((h == hse) || (cnt == 0));
      e.vs_r = act && (h == ht - 1) && (v + 1 == vss);
      e.vs_s = act && (((h == ht - 1) && (v + 1 == vse)) || (cnt == 0));
      e.vis  = (h < hv) && (v < vv);
      e.ls   = act && (h == 0);
      e.fs   = act && (h == 0) && (v == 0);
      e.hlvl = !((h > hss) && (h <= hse));
      e.vlvl = !((v >= vss) && (v < vse));
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", name, act, exp, n, $time);
      end
   endtask

   int  d_low_cnt = 0;
   int  s_fs_cnt = 0;
   int  s_vis_cnt = 0;
   bit  f656 = 0, f752 = 0, f800 = 0, f74 = 0, f104 = 0, f270 = 0;
`ifdef VGA_FRAME_COUNT_EN
   bit  f135 = 0, f256f = 0;
`endif

   always @(negedge clk) begin
      exp_t ed, es;
      ed = model(n, pe, rst_n, 640, 16, 96, 48, 480, 10, 2, 33);
      es = model(n, pe, rst_n, 8, 2, 3, 2, 4, 1, 2, 2);

      chk("d_h_count", 32'(d_h_count), 32'(ed.h));
      chk("d_v_count", 32'(d_v_count), 32'(ed.v));
      chk("d_hs_reset", 32'(d_hs_reset), 32'(ed.hs_r));
      chk("d_hs_set", 32'(d_hs_set), 32'(ed.hs_s));
      chk("d_vs_reset", 32'(d_vs_reset), 32'(ed.vs_r));
      chk("d_vs_set", 32'(d_vs_set), 32'(ed.vs_s));
      chk("d_visible", 32'(d_visible), 32'(ed.vis));
      chk("d_line_start", 32'(d_line_start), 32'(ed.ls));
      chk("d_frame_start", 32'(d_frame_start), 32'(ed.fs));
      chk("s_h_count", 32'(s_h_count), 32'(es.h));
      chk("s_v_count", 32'(s_v_count), 32'(es.v));
      chk("s_hs_reset", 32'(s_hs_reset), 32'(es.hs_r));
      chk("s_hs_set", 32'(s_hs_set), 32'(es.hs_s));
      chk("s_vs_reset", 32'(s_vs_reset), 32'(es.vs_r));
      chk("s_vs_set", 32'(s_vs_set), 32'(es.vs_s));
      chk("s_visible", 32'(s_visible), 32'(es.vis));
      chk("s_line_start", 32'(s_line_start), 32'(es.ls));
      chk("s_frame_start", 32'(s_frame_start), 32'(es.fs));
`ifdef VGA_FRAME_COUNT_EN
      chk("d_frame_count", 32'(d_frame_count), 32'(ed.fc));
      chk("s_frame_count", 32'(s_frame_count), 32'(es.fc));
`endif
      // Sync levels are defined once the init pulses have been applied.
      if (rst_n && n >= 1) begin
         chk("d_hsync_lvl", 32'(d_hq), 32'(ed.hlvl));
         chk("d_vsync_lvl", 32'(d_vq), 32'(ed.vlvl));
         chk("s_hsync_lvl", 32'(s_hq), 32'(es.hlvl));
         chk("s_vsync_lvl", 32'(s_vq), 32'(es.vlvl));
      end

      // Hand-computed pins.
      if (!rst_n) begin
         d_low_cnt = 0; s_fs_cnt = 0; s_vis_cnt = 0;
      end else if (pe) begin
         if (n == 0) begin
            chk("init_hs_set", 32'(d_hs_set), 32'd1);
            chk("init_vs_set", 32'(d_vs_set), 32'd1);
            chk("init_hs_reset", 32'(d_hs_reset), 32'd0);
            chk("init_vs_reset", 32'(d_vs_reset), 32'd0);
         end
         if (n == 1) begin
            chk("second_hs_set", 32'(d_hs_set), 32'd0);
            chk("second_vs_set", 32'(d_vs_set), 32'd0);
         end
         if (n >= 1 && n < 800 && !d_hq) d_low_cnt++;
         if (n < 270) begin
            if (s_frame_start) s_fs_cnt++;
            if (s_visible) s_vis_cnt++;
         end
         if (n == 656 && !f656) begin f656 = 1; chk("hs_reset_at_656", 32'(d_hs_reset), 32'd1); end
         if (n == 752 && !f752) begin f752 = 1; chk("hs_set_at_752", 32'(d_hs_set), 32'd1); end
         if (n == 800 && !f800) begin
            f800 = 1;
            chk("wrap_h_count", 32'(d_h_count), 32'd0);
            chk("wrap_v_count", 32'(d_v_count), 32'd1);
            chk("wrap_line_start", 32'(d_line_start), 32'd1);
            chk("hsync_low_periods", 32'(d_low_cnt), 32'd96);
         end
         if (n == 74 && !f74) begin f74 = 1; chk("s_vs_reset_l4", 32'(s_vs_reset), 32'd1); end
         if (n == 104 && !f104) begin f104 = 1; chk("s_vs_set_l6", 32'(s_vs_set), 32'd1); end
         if (n == 270 && !f270) begin
            f270 = 1;
            chk("s_frame_starts_2f", 32'(s_fs_cnt), 32'd2);
            chk("s_visible_2f", 32'(s_vis_cnt), 32'd64);
         end
`ifdef VGA_FRAME_COUNT_EN
         if (n == 135 && !f135) begin f135 = 1; chk("s_fc_after_1", 32'(s_frame_count), 32'd1); end
         if (n == 34560 && !f256f) begin f256f = 1; chk("s_fc_wrap_256", 32'(s_frame_count), 32'd0); end
`endif
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_d_h_count", 32'(d_h_count), 32'd0);
      chk("rst_d_v_count", 32'(d_v_count), 32'd0);
      chk("rst_d_visible", 32'(d_visible), 32'd1);
      chk("rst_d_hs_set", 32'(d_hs_set), 32'd0);
      $display("reset held: h=%0d v=%0d visible=%0d", d_h_count, d_v_count, d_visible);

      // Continuous pixel_en: first line, wrap, and several small frames.
      @(posedge clk); #1 rst_n = 1'b1; pe = 1'b1;
      repeat (1700) @(posedge clk);
      $display("continuous run: n=%0d d=(%0d,%0d) s=(%0d,%0d)", n, d_h_count, d_v_count, s_h_count, s_v_count);

      // pixel_en every second clock.
      for (int i = 0; i < 800; i++) begin
         #1 pe = (i % 2 == 1);
         @(posedge clk);
      end
      $display("half-rate run: n=%0d d=(%0d,%0d)", n, d_h_count, d_v_count);

      // Mid-frame asynchronous reset with pixel_en still high.
      #1 pe = 1'b1; rst_n = 1'b0;
      #1;
      chk("async_d_h_count", 32'(d_h_count), 32'd0);
      chk("async_d_v_count", 32'(d_v_count), 32'd0);
      chk("async_s_h_count", 32'(s_h_count), 32'd0);
      chk("async_d_hs_set", 32'(d_hs_set), 32'd0);
      chk("async_d_vs_set", 32'(d_vs_set), 32'd0);
      chk("async_s_hs_reset", 32'(s_hs_reset), 32'd0);
      $display("async reset: h=%0d v=%0d", d_h_count, d_v_count);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (300) @(posedge clk);
      $display("post-reset run: n=%0d s=(%0d,%0d)", n, s_h_count, s_v_count);

`ifdef VGA_FRAME_COUNT_EN
      repeat (34700) @(posedge clk);
      $display("frame-count run: n=%0d s_frame_count=%0d", n, s_frame_count);
      chk("reached_256_frames", 32'(f256f), 32'd1);
`endif
      chk("reached_line_pins", 32'(f656 & f752 & f800), 32'd1);
      chk("reached_frame_pins", 32'(f74 & f104 & f270), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
- Upstream of the hsync/vsync SR flip-flops (ffsr) in the VGA controller.
- Runs horizontal and vertical pixel counters and issues single-clock set/reset pulses. Each ffsr instance turns its pulses into a sync level.
- Also provides pixel coordinates, a visible-area flag and line/frame strobes to the pixel generator.
- Defaults give 640x480@60 timing, advancing one pixel per pixel_en.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels, >=1)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines, >=1)
- V_BACK, 33, vertical back porch (lines)
- CNT_W, 10, width of h_count/v_count; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- pixel_en  in  1  pixel advance enable, one clock wide (e.g. every 2nd clock)
- hs_reset  out  1  pulse: drive hsync ffsr r (sync start, q->0)
- hs_set  out  1  pulse: drive hsync ffsr s (sync end, q->1)
- vs_reset  out  1  pulse: drive vsync ffsr r
- vs_set  out  1  pulse: drive vsync ffsr s
- h_count  out  CNT_W  current pixel column
- v_count  out  CNT_W  current line
- visible  out  1  h_count<H_VISIBLE and v_count<V_VISIBLE
- line_start  out  1  pulse on the pixel_en cycle where h_count==0
- frame_start  out  1  pulse on the pixel_en cycle where h_count==0 and v_count==0

Behaviour:
- Derived values:
  - H_TOTAL=sum of the H_* parameters (800); V_TOTAL=sum of the V_* parameters (525).
  - HS_START=H_VISIBLE+H_FRONT; HS_END=HS_START+H_SYNC.
  - VS_START=V_VISIBLE+V_FRONT; VS_END=VS_START+V_SYNC.
- Reset (async, clear_n=0): h_count=0, v_count=0, init_pending=1. All pulse outputs 0 immediately. visible reads 1, since it decodes 0,0. Reset mid-frame restarts at 0,0 with no partial sync pulse emitted.
- Counters are registered and change only on pixel_en.
  - h_count wraps from H_TOTAL-1 to 0.
  - v_count increments on the h wrap and wraps from V_TOTAL-1 to 0 on the same edge.
  - pixel_en=0 holds all state.
- All pulse outputs are combinational decodes of registered state, qualified by pixel_en, so each is exactly one clock wide.
  - hs_reset: h_count==HS_START.
  - hs_set: h_count==HS_END, or init_pending.
  - vs_reset: h_count==H_TOTAL-1 and v_count==VS_START-1.
  - vs_set: h_count==H_TOTAL-1 and v_count==VS_END-1, or init_pending.
- Resulting sync waveforms (downstream ffsr updates on the same edge the counter advances):
  - hsync is low for exactly H_SYNC pixel periods, while h_count is HS_START+1..HS_END.
  - vsync is low for exactly lines VS_START..VS_END-1.
- init_pending clears on the first pixel_en after reset. It forces both syncs inactive regardless of the ffsr reset value.
- A set and a reset to the same ffsr never occur in one cycle. This holds for any legal parameters (H_SYNC>=1, V_SYNC>=1, HS_END<H_TOTAL).
- visible and the counts are valid every cycle, including cycles without pixel_en.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- Defined: adds output frame_count [7:0]. It resets to 0, increments on the pixel_en edge where both counters wrap to 0, and wraps from 255 to 0.
- Undefined: no port, no register; all other behaviour identical.

Decomposition:
- Package vga_timing_pkg holds the default 640x480 parameter values plus the derived H_TOTAL, V_TOTAL, HS_START/END and VS_START/END expressions. The pixel generator shares these.
- One natural sub-module: mod_counter (parameter MOD, WIDTH; inputs clock, clear_n, en; outputs count, wrap). It is instantiated twice:
  - horizontal: en=pixel_en;
  - vertical: en=pixel_en & h_wrap.

Test Plan:
- Reset, then pixel_en every clock: on first pixel_en, hs_set=vs_set=1, hs_reset=vs_reset=0; on second pixel_en, no set pulses.
- Full line with ffsr attached: hs_reset only at h_count=656, hs_set at 752; hsync low for 96 pixel_en periods; h_count wraps 799->0 with line_start at 0.
- Full frame: vs_reset at line 489/h=799, vs_set at line 491/h=799; vsync low exactly lines 490-491; frame_start once per 420000 pixel_en pulses; visible true for 307200 of them.
- pixel_en every 2nd clock: counts hold between enables; every pulse is one clock wide and coincides with pixel_en.
- Assert clear_n=0 at h=700, v=300 for 3 clocks: outputs drop asynchronously; after release, restart at 0,0 with init set pulses.
- VGA_FRAME_COUNT_EN defined: frame_count reads 0, 1, 2 after 0, 1, 2 complete frames; after 256 frames it wraps to 0.
